// File: rtl/serial_adder_n.sv
// Bit-serial adder/subtractor: one full-adder slice and a carry flop consume a WIDTH-bit
// operand pair LSB-first, one bit per clock, then report s/cout/ovf with a done pulse.
module serial_adder_n #(
   parameter int WIDTH  = 8,
   parameter bit SUB_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf,
   output logic [1:0]       state_dbg
);

   // Handshake: a request is taken on any rising edge where start=1 and ready=1;
   // the result is final when done=1 (one cycle) and holds until the next acceptance.

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] s_q;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             cout_q;
   logic             ovf_q;

   logic sub_eff;
   logic accept;
   logic last_step;
   logic sum_bit;
   logic carry_nx;

   assign sub_eff   = SUB_EN & sub;
   assign accept    = (state == IDLE) && start;
   assign last_step = (state == RUN) && (cnt == CW'(WIDTH - 1));
   assign sum_bit   = a_sh[0] ^ b_sh[0] ^ carry;
   assign carry_nx  = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (start) state_nx = RUN;
         RUN:  if (last_step) state_nx = DONE;
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Subtraction is a + ~b + 1, so the inverted operand and forced carry are set up once here.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         s_q    <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (accept) begin
         a_sh   <= a;
         b_sh   <= sub_eff ? ~b : b;
         carry  <= sub_eff ? 1'b1 : cin;
         s_q    <= '0;
         cnt    <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (state == RUN) begin
         s_q   <= {sum_bit, s_q[WIDTH-1:1]};
         a_sh  <= a_sh >> 1;
         b_sh  <= b_sh >> 1;
         carry <= carry_nx;
         cnt   <= cnt + 1'b1;
         if (last_step) begin
            // carry here is the carry into the MSB slice
            cout_q <= carry_nx;
            ovf_q  <= carry ^ carry_nx;
         end
      end
   end

   assign ready     = (state == IDLE);
   assign busy      = (state == RUN);
   assign done      = (state == DONE);
   assign s         = s_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
   assign state_dbg = state;

endmodule

// File: tb/tb_serial_adder_n.sv
// Bench for serial_adder_n: WIDTH=8 adder/subtractor plus WIDTH=3 instances with and
// without subtraction, checked against an integer-arithmetic reference model.
module tb_serial_adder_n;

   logic clk;
   logic rst_n;

   logic       start8, sub8, cin8;
   logic [7:0] a8, b8;
   logic       ready8, busy8, done8, cout8, ovf8;
   logic [7:0] s8;
   logic [1:0] st8;

   logic       start3, sub3, cin3;
   logic [2:0] a3, b3;
   logic       ready3, busy3, done3, cout3, ovf3;
   logic [2:0] s3;
   logic [1:0] st3;

   logic       start3n, sub3n, cin3n;
   logic [2:0] a3n, b3n;
   logic       ready3n, busy3n, done3n, cout3n, ovf3n;
   logic [2:0] s3n;
   logic [1:0] st3n;

   int n_tests = 0;
   int n_fail  = 0;

   logic [9:0] exp_q[$];

   serial_adder_n #(.WIDTH(8), .SUB_EN(1'b1)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
      .ready(ready8), .busy(busy8), .done(done8), .s(s8), .cout(cout8), .ovf(ovf8),
      .state_dbg(st8));

   serial_adder_n #(.WIDTH(3), .SUB_EN(1'b1)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .sub(sub3), .a(a3), .b(b3), .cin(cin3),
      .ready(ready3), .busy(busy3), .done(done3), .s(s3), .cout(cout3), .ovf(ovf3),
      .state_dbg(st3));

   serial_adder_n #(.WIDTH(3), .SUB_EN(1'b0)) dut3n (
      .clk(clk), .rst_n(rst_n), .start(start3n), .sub(sub3n), .a(a3n), .b(b3n), .cin(cin3n),
      .ready(ready3n), .busy(busy3n), .done(done3n), .s(s3n), .cout(cout3n), .ovf(ovf3n),
      .state_dbg(st3n));

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: returns {ovf, cout, s[7:0]} from plain integer arithmetic.
   function automatic logic [9:0] ref_op(int w, bit sub_en, int a, int b, bit cin, bit sub);
      int  mask;
      int  full;
      int  sa;
      int  sb;
      int  sres;
      bit  do_sub;
      bit  co;
      bit  ov;
      logic [7:0] sv;
      mask   = (1 << w) - 1;
      do_sub = sub & sub_en;
      if (do_sub) full = a + ((~b) & mask) + 1;
      else        full = a + b + int'(cin);
      sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
      sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
      sres = do_sub ? sa - sb : sa + sb + int'(cin);
      ov = (sres > (1 << (w - 1)) - 1) || (sres < -(1 << (w - 1)));
      co = ((full >> w) & 1) != 0;
      sv = 8'(full & mask);
      return {ov, co, sv};
   endfunction

   // driver tasks
   task automatic drive(input int sel, input logic st, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sub);
      case (sel)
         0: begin start8 = st; a8 = a; b8 = b; cin8 = cin; sub8 = sub; end
         1: begin start3 = st; a3 = a[2:0]; b3 = b[2:0]; cin3 = cin; sub3 = sub; end
         default: begin start3n = st; a3n = a[2:0]; b3n = b[2:0]; cin3n = cin; sub3n = sub; end
      endcase
   endtask

   function automatic logic get_ready(int sel);
      case (sel)
         0: return ready8;
         1: return ready3;
         default: return ready3n;
      endcase
   endfunction

   function automatic logic get_done(int sel);
      case (sel)
         0: return done8;
         1: return done3;
         default: return done3n;
      endcase
   endfunction

   function automatic logic [9:0] get_res(int sel);
      case (sel)
         0: return {ovf8, cout8, s8};
         1: return {ovf3, cout3, 5'b0, s3};
         default: return {ovf3n, cout3n, 5'b0, s3n};
      endcase
   endfunction

   // One operation: returns result, edges from acceptance to done (-1 on timeout),
   // and whether done dropped with ready back after one cycle. Junk is driven while busy.
   task automatic do_op(input int sel, input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic sub, output logic [9:0] res, output int lat,
                        output logic done_one);
      res = '0;
      lat = -1;
      for (int i = 0; i < 20 && !get_ready(sel); i++) begin
         @(posedge clk); #1;
      end
      drive(sel, 1'b1, a, b, cin, sub);
      @(posedge clk); #1;
      for (int i = 1; i <= 32; i++) begin
         drive(sel, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         @(posedge clk); #1;
         if (get_done(sel)) begin
            lat = i;
            res = get_res(sel);
            break;
         end
      end
      drive(sel, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      @(posedge clk); #1;
      done_one = !get_done(sel) && get_ready(sel);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      drive(0, 1'b1, 8'hA5, 8'h5A, 1'b1, 1'b0);
      drive(1, 1'b0, 8'h0, 8'h0, 1'b0, 1'b0);
      drive(2, 1'b0, 8'h0, 8'h0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({ready8, busy8, done8} !== 3'b100) begin
         n_fail++;
         $display("FAIL reset_flags: got rdy/busy/done=%b required 100", {ready8, busy8, done8});
      end
      n_tests++;
      if ({ovf8, cout8, s8} !== 10'h000) begin
         n_fail++;
         $display("FAIL reset_outputs: got ovf/cout/s=%h required 000", {ovf8, cout8, s8});
      end
      drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_tests++;
      if ({ready8, busy8} !== 2'b10) begin
         n_fail++;
         $display("FAIL reset_no_accept: got rdy/busy=%b required 10", {ready8, busy8});
      end
   endtask

   task automatic test_directed;
      logic [7:0] va[4]  = '{8'h5A, 8'hFF, 8'h10, 8'h80};
      logic [7:0] vb[4]  = '{8'h3C, 8'h01, 8'h20, 8'h01};
      logic       vc[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic       vs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic [9:0] exp[4] = '{{2'b10, 8'h96}, {2'b01, 8'h01}, {2'b00, 8'hF0}, {2'b11, 8'h7F}};
      logic [9:0] res;
      int         lat;
      logic       d1;
      for (int i = 0; i < 4; i++) begin
         do_op(0, va[i], vb[i], vc[i], vs[i], res, lat, d1);
         n_tests++;
         if (res !== exp[i]) begin
            n_fail++;
            $display("FAIL directed_%0d: got ovf/cout/s=%h required %h", i, res, exp[i]);
         end
         n_tests++;
         if (lat != 8) begin
            n_fail++;
            $display("FAIL latency_%0d: got %0d edges after acceptance required 8", i, lat);
         end
         n_tests++;
         if (d1 !== 1'b1) begin
            n_fail++;
            $display("FAIL done_width_%0d: got done-dropped/ready=%b required 1", i, d1);
         end
      end
   endtask

   task automatic test_random;
      logic [9:0] res;
      logic [9:0] exp;
      int         lat;
      logic       d1;
      logic [7:0] a;
      logic [7:0] b;
      logic       c;
      logic       sb;
      for (int i = 0; i < 24; i++) begin
         a  = 8'($urandom);
         b  = 8'($urandom);
         c  = 1'($urandom_range(0, 1));
         sb = 1'($urandom_range(0, 1));
         exp = ref_op(8, 1'b1, int'(a), int'(b), c, sb);
         do_op(0, a, b, c, sb, res, lat, d1);
         n_tests++;
         if (res !== exp || lat != 8) begin
            n_fail++;
            $display("FAIL random_%0d: a=%h b=%h cin=%b sub=%b got %h lat %0d required %h lat 8",
                     i, a, b, c, sb, res, lat, exp);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [9:0] exp;
      exp_q.delete();
      drive(0, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      for (int k = 0; k < 40; k++) begin
         if (k % 10 == 0) exp_q.push_back(ref_op(8, 1'b1, int'(a8), int'(b8), cin8, sub8));
         @(posedge clk); #1;
         n_tests++;
         if (done8 !== (k % 10 == 8) || ready8 !== (k % 10 == 9)) begin
            n_fail++;
            $display("FAIL b2b_timing_%0d: got done/ready=%b%b required %b%b", k, done8, ready8,
                     (k % 10 == 8), (k % 10 == 9));
         end
         if (done8 === 1'b1 && exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            n_tests++;
            if ({ovf8, cout8, s8} !== exp) begin
               n_fail++;
               $display("FAIL b2b_result_%0d: got %h required %h", k, {ovf8, cout8, s8}, exp);
            end
         end
         drive(0, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
      end
      drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL b2b_drain: got %0d results left required 0", exp_q.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_midrun;
      logic [9:0] res;
      int         lat;
      logic       d1;
      int         spurious;
      drive(0, 1'b1, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
      @(posedge clk); #1;
      drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      n_tests++;
      if ({ready8, busy8, done8} !== 3'b100 || {ovf8, cout8, s8} !== 10'h000) begin
         n_fail++;
         $display("FAIL midrun_reset: got rdy/busy/done=%b res=%h required 100 res=000",
                  {ready8, busy8, done8}, {ovf8, cout8, s8});
      end
      spurious = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (done8 !== 1'b0) spurious++;
      end
      n_tests++;
      if (spurious != 0) begin
         n_fail++;
         $display("FAIL midrun_no_done: got %0d done cycles required 0", spurious);
      end
      do_op(0, 8'h01, 8'h01, 1'b0, 1'b0, res, lat, d1);
      n_tests++;
      if (res[7:0] !== 8'h02 || lat != 8) begin
         n_fail++;
         $display("FAIL midrun_recover: got s=%h lat %0d required s=02 lat 8", res[7:0], lat);
      end
   endtask

   task automatic test_exhaustive_w3;
      logic [9:0] res;
      logic [9:0] exp;
      int         lat;
      logic       d1;
      for (int a = 0; a < 8; a++)
         for (int b = 0; b < 8; b++)
            for (int c = 0; c < 2; c++)
               for (int sb = 0; sb < 2; sb++) begin
                  exp = ref_op(3, 1'b1, a, b, c[0], sb[0]);
                  do_op(1, 8'(a), 8'(b), c[0], sb[0], res, lat, d1);
                  n_tests++;
                  if (res !== exp || lat != 3 || d1 !== 1'b1) begin
                     n_fail++;
                     $display("FAIL w3_%0d_%0d_%0d_%0d: got %h lat %0d d1 %b required %h lat 3 d1 1",
                              a, b, c, sb, res, lat, d1, exp);
                  end
               end
   endtask

   task automatic test_add_only_w3;
      logic [9:0] res;
      logic [9:0] exp;
      int         lat;
      logic       d1;
      for (int a = 0; a < 8; a++)
         for (int b = 0; b < 8; b++)
            for (int c = 0; c < 2; c++) begin
               exp = ref_op(3, 1'b0, a, b, c[0], 1'b1);
               do_op(2, 8'(a), 8'(b), c[0], 1'b1, res, lat, d1);
               n_tests++;
               if (res !== exp || lat != 3) begin
                  n_fail++;
                  $display("FAIL w3_addonly_%0d_%0d_%0d: got %h lat %0d required %h lat 3",
                           a, b, c, res, lat, exp);
               end
            end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_midrun();
      test_exhaustive_w3();
      test_add_only_w3();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
